oam_scan_seq: RTL and testbench
===============================

# oam_scan_seq

Behavioural OAM scan sequencer for mode 2 of each visible line. It walks all 40 OAM entries, compares each sprite's Y against the current line using the configured sprite height, and writes up to 10 matching sprites into the sprite store. That store is consumed by the sprite match/fetch control downstream. The block replaces the gate-level scan counter and Y comparator as a single clocked unit.

## Interface
Parameters:
- `N_ENTRIES`, 40: number of OAM entries scanned per line.
- `N_SLOTS`, 10: sprite store capacity per line.

Ports:
- `clk1`  in  1  system clock; all state updates on its rising edge.
- `nreset_video`  in  1  reset, synchronous, active-low.
- `start`  in  1  single-cycle pulse; begins a scan of the line given by `v`.
- `v`  in  8  current line (LY), sampled on the `start` cycle.
- `ff40_d2`  in  1  sprite height select: 0 = 8 rows, 1 = 16 rows. Sampled on `start`.
- `oam_rd`  out  1  OAM read request.
- `oam_idx`  out  6  OAM entry index being read.
- `oam_a_d`  in  8  OAM byte 0 (Y), valid the cycle after `oam_rd`.
- `oam_b_d`  in  8  OAM byte 1 (X), valid the cycle after `oam_rd`.
- `store_we`  out  1  sprite store write strobe, one cycle.
- `store_slot`  out  4  store slot written (0..9).
- `store_idx`  out  6  OAM index of the stored sprite.
- `store_line`  out  4  row within the sprite for this line.
- `store_x`  out  8  sprite X byte.
- `spr_count`  out  4  matches stored so far this line (0..10).
- `busy`  out  1  scan in progress.
- `done`  out  1  single-cycle pulse after the last entry is evaluated.

## Operation
- FSM states: IDLE, ADDR, DATA.
  - IDLE -> ADDR on `start`. This transition latches `v` and `ff40_d2`, clears `spr_count`, and sets `oam_idx`=0.
  - ADDR: `oam_rd`=1 -> DATA.
  - DATA: evaluate the entry.
    - If `oam_idx`=39 -> IDLE with `done`=1.
    - Otherwise increment `oam_idx` -> ADDR.
- Match arithmetic (9-bit, two's complement): `d = {0,v} + 16 - {0,oam_a_d}`.
  - Match iff 0 <= d < h, where h = 8 or 16.
  - `store_line` = d[3:0]. In 8-row mode, d[3] is always 0.
- On a match in DATA with `spr_count` < 10:
  - `store_we`=1 for that cycle.
  - `store_slot`=`spr_count`, `store_idx`=`oam_idx`, `store_x`=`oam_b_d`.
  - `spr_count` increments on the same edge.
- Matches found with `spr_count`=10 are dropped. The scan still runs to entry 39.
- X is not checked. Sprites with X=0 or X>=168 consume a slot.
- `busy`=1 in ADDR and DATA.
- `spr_count` holds its value after `done` until the next `start`.
- `start` while busy aborts the current scan and restarts at entry 0 with the count cleared. No `done` is issued for the aborted scan.
- `start` coincident with the final DATA cycle: the restart wins, and `done` is suppressed.

## Timing
- 2 cycles per entry; 80 cycles from the `start` edge to the last DATA cycle.
- `done` is asserted during cycle 80, the final DATA cycle.
- `oam_rd` timing: high during ADDR; data is sampled in the following DATA cycle (1-cycle read latency).
- `store_*` outputs are combinational from DATA-state registers plus the OAM inputs, and are valid only while `store_we`=1.
- Reset (`nreset_video`=0 at a clock edge) takes effect at that edge, including mid-scan, and leaves these values:
  - State: IDLE.
  - Zero: `oam_idx`, `oam_rd`, `store_we`, `spr_count`, `busy`, `done`, latched line, latched height.
  - `store_slot`/`store_idx`/`store_line`/`store_x` = 0.

## Configuration
- `OAM_SCAN_TALL_SPRITE_EN` defined:
  - `ff40_d2` selects 8/16-row height as described above.
- `OAM_SCAN_TALL_SPRITE_EN` undefined:
  - `ff40_d2` is ignored and h is fixed at 8.
  - `store_line[3]` is tied 0.
  - The latched height register is removed.

## Test plan
- Reset mid-scan:
  - Stimulus: assert `nreset_video`=0 at cycle 30 of a scan.
  - Required: next cycle `busy`=0 and `spr_count`=0; no `done` and no `store_we` until a new `start`.
- Single match:
  - Stimulus: `v`=0, `ff40_d2`=0; entry 5 Y=16, X=40; all others Y=0.
  - Required: one `store_we` at cycle 12 with slot 0, idx 5, line 0, x 40; `done` at cycle 80; `spr_count`=1.
- Capacity limit:
  - Stimulus: all 40 entries Y=20, `v`=10.
  - Required: 10 writes to slots 0..9 for idx 0..9 with line 6; entries 10..39 are dropped; `spr_count`=10.
- Tall sprites:
  - Stimulus: `ff40_d2`=1, `v`=10; entry 0 Y=12, entry 1 Y=28.
  - Required: entry 0 stored with line 14; entry 1 rejected (d=-2).
  - With `OAM_SCAN_TALL_SPRITE_EN` undefined, entry 0 is rejected.
- Wrap and boundary:
  - Stimulus: `v`=143, entries with Y=152, Y=159, Y=160, Y=0.
  - Required: Y=152 -> line 7; Y=159 -> line 0; Y=160 and Y=0 rejected.
- Restart:
  - Stimulus: `start` at cycle 40 of an in-progress scan.
  - Required: `oam_idx` returns to 0 and `spr_count` clears; exactly one `done`, 80 cycles after the second `start`.

Source files
------------

// File: rtl/oam_scan_seq.sv
// OAM scan sequencer: walks every OAM entry during mode 2 and writes up to N_SLOTS Y-matching sprites to the sprite store.
// Optional tall-sprite support: define OAM_SCAN_TALL_SPRITE_EN to honour ff40_d2 (8/16-row sprites); otherwise height is fixed at 8.
module oam_scan_seq #(
    parameter int N_ENTRIES = 40,
    parameter int N_SLOTS   = 10
) (
    input  logic       clk1,
    input  logic       nreset_video,
    input  logic       start,
    input  logic [7:0] v,
    input  logic       ff40_d2,
    output logic       oam_rd,
    output logic [5:0] oam_idx,
    input  logic [7:0] oam_a_d,
    input  logic [7:0] oam_b_d,
    output logic       store_we,
    output logic [3:0] store_slot,
    output logic [5:0] store_idx,
    output logic [3:0] store_line,
    output logic [7:0] store_x,
    output logic [3:0] spr_count,
    output logic       busy,
    output logic       done,
    output logic [1:0] scan_state
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } state_t;

    localparam logic [5:0] LAST_IDX = 6'(N_ENTRIES - 1);
    localparam logic [3:0] MAX_CNT  = 4'(N_SLOTS);

    state_t     state;
    state_t     state_nx;
    logic [5:0] idx_q;
    logic [3:0] cnt_q;
    logic [7:0] line_q;
    logic [8:0] d;
    logic [8:0] h;
    logic       hit;
    logic       last_entry;

`ifdef OAM_SCAN_TALL_SPRITE_EN
    logic tall_q;
`else
    logic unused_ff40_d2;
    assign unused_ff40_d2 = ff40_d2;
`endif

    assign last_entry = (idx_q == LAST_IDX);

    always_ff @(posedge clk1) begin
        if (!nreset_video) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // start is honoured in any state, so a restart simply reloads the datapath
    always_ff @(posedge clk1) begin
        if (!nreset_video) begin
            idx_q  <= '0;
            cnt_q  <= '0;
            line_q <= '0;
`ifdef OAM_SCAN_TALL_SPRITE_EN
            tall_q <= 1'b0;
`endif
        end else if (start) begin
            idx_q  <= '0;
            cnt_q  <= '0;
            line_q <= v;
`ifdef OAM_SCAN_TALL_SPRITE_EN
            tall_q <= ff40_d2;
`endif
        end else begin
            if (state == DATA && !last_entry) begin
                idx_q <= idx_q + 6'd1;
            end
            if (store_we) begin
                cnt_q <= cnt_q + 4'd1;
            end
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = IDLE;
            ADDR:    state_nx = DATA;
            DATA:    state_nx = last_entry ? IDLE : ADDR;
            default: state_nx = IDLE;
        endcase
        if (start) begin
            state_nx = ADDR;
        end
    end

    always_comb begin
        d = {1'b0, line_q} + 9'd16 - {1'b0, oam_a_d};
`ifdef OAM_SCAN_TALL_SPRITE_EN
        h = tall_q ? 9'd16 : 9'd8;
`else
        h = 9'd8;
`endif
        // d[8] set means the sprite starts below this line
        hit        = !d[8] && (d < h);
        oam_rd     = (state == ADDR);
        busy       = (state != IDLE);
        oam_idx    = idx_q;
        spr_count  = cnt_q;
        scan_state = state;
        done       = (state == DATA) && last_entry && !start;
        store_we   = (state == DATA) && hit && (cnt_q < MAX_CNT) && !start;
        store_slot = '0;
        store_idx  = '0;
        store_line = '0;
        store_x    = '0;
        if (store_we) begin
            store_slot = cnt_q;
            store_idx  = idx_q;
`ifdef OAM_SCAN_TALL_SPRITE_EN
            store_line = d[3:0];
`else
            store_line = {1'b0, d[2:0]};
`endif
            store_x    = oam_b_d;
        end
    end

endmodule

// File: tb/tb_oam_scan_seq.sv
// Bench for oam_scan_seq: directed and random scans checked every cycle against a timeline model built from the scan rules.
module tb_oam_scan_seq;

    logic       clk1;
    logic       nreset_video;
    logic       start;
    logic [7:0] v;
    logic       ff40_d2;
    logic       oam_rd;
    logic [5:0] oam_idx;
    logic [7:0] oam_a_d;
    logic [7:0] oam_b_d;
    logic       store_we;
    logic [3:0] store_slot;
    logic [5:0] store_idx;
    logic [3:0] store_line;
    logic [7:0] store_x;
    logic [3:0] spr_count;
    logic       busy;
    logic       done;
    logic [1:0] scan_state;

`ifdef OAM_SCAN_TALL_SPRITE_EN
    localparam bit TALL = 1'b1;
`else
    localparam bit TALL = 1'b0;
`endif

    oam_scan_seq dut (
        .clk1(clk1), .nreset_video(nreset_video), .start(start), .v(v), .ff40_d2(ff40_d2),
        .oam_rd(oam_rd), .oam_idx(oam_idx), .oam_a_d(oam_a_d), .oam_b_d(oam_b_d),
        .store_we(store_we), .store_slot(store_slot), .store_idx(store_idx),
        .store_line(store_line), .store_x(store_x), .spr_count(spr_count),
        .busy(busy), .done(done), .scan_state(scan_state)
    );

    // clock / reset
    initial clk1 = 1'b0;
    always #5 clk1 = ~clk1;

    // OAM contents and expected per-cycle write timeline of the current scan
    logic [7:0] y_mem[40];
    logic [7:0] x_mem[40];
    bit         exp_we[0:95];
    logic [3:0] exp_slot[0:95];
    logic [5:0] exp_idx[0:95];
    logic [3:0] exp_line[0:95];
    logic [7:0] exp_x[0:95];
    int         exp_total;

    int cyc = -1;
    int cnt_m = 0;
    int n_cmp = 0;
    int n_bad = 0;
    int done_seen = 0;
    int we_seen = 0;
    bit checking = 0;
    bit rd_pending = 0;
    logic [5:0] rd_idx = '0;

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t cyc=%0d)", nm, act, exp, $time, cyc);
        end
    endtask

    // Entry k is read in cycle 2k+1 and evaluated in cycle 2k+2 after the start edge.
    function automatic void compute_model(input logic [7:0] lv, input bit lff);
        int h;
        int count;
        logic [8:0] dd;
        h = (TALL && lff) ? 16 : 8;
        count = 0;
        for (int c = 0; c < 96; c++) exp_we[c] = 1'b0;
        for (int k = 0; k < 40; k++) begin
            dd = 9'(int'(lv) + 16 - int'(y_mem[k]));
            if (!dd[8] && int'(dd) < h && count < 10) begin
                exp_we[2*k+2]   = 1'b1;
                exp_slot[2*k+2] = 4'(count);
                exp_idx[2*k+2]  = 6'(k);
                exp_line[2*k+2] = dd[3:0];
                exp_x[2*k+2]    = x_mem[k];
                count++;
            end
        end
        exp_total = count;
    endfunction

    // OAM responder: one-cycle read latency, garbage on the bus otherwise
    always @(negedge clk1) begin
        rd_pending = (oam_rd === 1'b1);
        rd_idx = oam_idx;
    end
    always @(posedge clk1) begin
        #1;
        if (rd_pending) begin
            oam_a_d = y_mem[rd_idx];
            oam_b_d = x_mem[rd_idx];
        end else begin
            oam_a_d = 8'($urandom);
            oam_b_d = 8'($urandom);
        end
    end

    // scan timeline: cycle number since the last start edge and committed match count
    always @(posedge clk1) begin
        if (!nreset_video) begin
            cyc = -1;
            cnt_m = 0;
        end else if (start) begin
            cyc = 1;
            cnt_m = 0;
        end else if (cyc >= 1) begin
            if (cyc <= 80 && exp_we[cyc]) cnt_m++;
            if (cyc < 1000) cyc++;
        end
    end

    // scoreboard compare, once per cycle on the falling edge
    always @(negedge clk1) begin
        bit act, e_we;
        if (checking && nreset_video) begin
            act  = (cyc >= 1 && cyc <= 80);
            e_we = act && exp_we[act ? cyc : 0] && !start;
            chk("busy", int'(busy), int'(act));
            chk("oam_rd", int'(oam_rd), int'(act && (cyc % 2 == 1)));
            chk("done", int'(done), int'(cyc == 80 && !start));
            chk("store_we", int'(store_we), int'(e_we));
            chk("spr_count", int'(spr_count), cnt_m);
            if (act) chk("oam_idx", int'(oam_idx), (cyc - 1) / 2);
            if (e_we && store_we) begin
                chk("store_slot", int'(store_slot), int'(exp_slot[cyc]));
                chk("store_idx", int'(store_idx), int'(exp_idx[cyc]));
                chk("store_line", int'(store_line), int'(exp_line[cyc]));
                chk("store_x", int'(store_x), int'(exp_x[cyc]));
            end
            if (cyc == -1) begin
                chk("idle_store_slot", int'(store_slot), 0);
                chk("idle_store_idx", int'(store_idx), 0);
                chk("idle_store_line", int'(store_line), 0);
                chk("idle_store_x", int'(store_x), 0);
            end
            if (done) done_seen++;
            if (store_we) we_seen++;
        end
    end

    // driver tasks
    task automatic tick();
        @(posedge clk1);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic fill(input logic [7:0] yv);
        for (int k = 0; k < 40; k++) begin
            y_mem[k] = yv;
            x_mem[k] = 8'($urandom);
        end
    endtask

    task automatic fill_random(input logic [7:0] lv);
        for (int k = 0; k < 40; k++) begin
            if ($urandom_range(0, 2) == 0) y_mem[k] = 8'($urandom);
            else y_mem[k] = 8'(int'(lv) + 16 - int'($urandom_range(0, 17)));
            x_mem[k] = 8'($urandom);
        end
    endtask

    // leaves the bench in cycle 1 of the new scan
    task automatic start_scan(input logic [7:0] lv, input bit lff);
        compute_model(lv, lff);
        start = 1'b1;
        v = lv;
        ff40_d2 = lff;
        tick();
        start = 1'b0;
        v = 8'($urandom);
        ff40_d2 = 1'($urandom);
    endtask

    initial begin
        logic [7:0] rv;
        start = 1'b0;
        v = '0;
        ff40_d2 = 1'b0;
        oam_a_d = '0;
        oam_b_d = '0;
        nreset_video = 1'b0;
        fill(8'd0);
        compute_model(8'd0, 1'b0);
        ticks(3);
        nreset_video = 1'b1;
        checking = 1'b1;
        ticks(3);
        chk("reset_busy", int'(busy), 0);
        chk("reset_count", int'(spr_count), 0);

        // single match at entry 5
        fill(8'd0);
        y_mem[5] = 8'd16;
        x_mem[5] = 8'd40;
        done_seen = 0;
        we_seen = 0;
        start_scan(8'd0, 1'b0);
        chk("single_pin_we12", int'(exp_we[12]), 1);
        chk("single_pin_idx", int'(exp_idx[12]), 5);
        chk("single_pin_slot", int'(exp_slot[12]), 0);
        chk("single_pin_line", int'(exp_line[12]), 0);
        chk("single_pin_x", int'(exp_x[12]), 40);
        ticks(80);
        chk("single_done", done_seen, 1);
        chk("single_writes", we_seen, 1);
        chk("single_count", int'(spr_count), 1);

        // capacity limit
        fill(8'd20);
        done_seen = 0;
        we_seen = 0;
        start_scan(8'd10, 1'b0);
        chk("cap_pin_total", exp_total, 10);
        chk("cap_pin_line", int'(exp_line[20]), 6);
        chk("cap_pin_idx9", int'(exp_idx[20]), 9);
        chk("cap_pin_drop10", int'(exp_we[22]), 0);
        ticks(80);
        chk("cap_writes", we_seen, 10);
        chk("cap_count", int'(spr_count), 10);
        ticks(5);
        chk("cap_count_hold", int'(spr_count), 10);

        // tall sprites
        fill(8'd0);
        y_mem[0] = 8'd12;
        y_mem[1] = 8'd28;
        we_seen = 0;
        start_scan(8'd10, 1'b1);
        chk("tall_pin_e0", int'(exp_we[2]), TALL ? 1 : 0);
        chk("tall_pin_line", int'(exp_we[2] ? exp_line[2] : 4'd14), 14);
        chk("tall_pin_e1", int'(exp_we[4]), 0);
        ticks(80);
        chk("tall_writes", we_seen, TALL ? 1 : 0);

        // wrap and boundary
        fill(8'd0);
        y_mem[0] = 8'd152;
        y_mem[1] = 8'd159;
        y_mem[2] = 8'd160;
        y_mem[3] = 8'd0;
        we_seen = 0;
        start_scan(8'd143, 1'b0);
        chk("bnd_pin_line7", int'(exp_line[2]), 7);
        chk("bnd_pin_line0", int'(exp_line[4]), 0);
        chk("bnd_pin_y160", int'(exp_we[6]), 0);
        chk("bnd_pin_y0", int'(exp_we[8]), 0);
        ticks(80);
        chk("bnd_writes", we_seen, 2);

        // restart at cycle 40
        rv = 8'($urandom_range(0, 150));
        fill_random(rv);
        start_scan(rv, 1'($urandom));
        ticks(39);
        done_seen = 0;
        fill_random(rv);
        start_scan(rv, 1'($urandom));
        ticks(80);
        chk("restart_done", done_seen, 1);
        chk("restart_count", int'(spr_count), exp_total);

        // restart coincident with the final DATA cycle
        fill_random(8'd60);
        start_scan(8'd60, 1'b0);
        ticks(79);
        done_seen = 0;
        start_scan(8'd60, 1'b1);
        ticks(80);
        chk("final_restart_done", done_seen, 1);

        // reset mid-scan at cycle 30
        fill(8'd20);
        start_scan(8'd10, 1'b0);
        ticks(29);
        nreset_video = 1'b0;
        tick();
        nreset_video = 1'b1;
        chk("midreset_busy", int'(busy), 0);
        chk("midreset_count", int'(spr_count), 0);
        done_seen = 0;
        we_seen = 0;
        ticks(20);
        chk("midreset_no_done", done_seen, 0);
        chk("midreset_no_we", we_seen, 0);

        // random scans, some aborted by a random restart
        for (int s = 0; s < 8; s++) begin
            rv = 8'($urandom);
            fill_random(rv);
            start_scan(rv, 1'($urandom));
            if ($urandom_range(0, 2) == 0) begin
                ticks($urandom_range(1, 78));
                rv = 8'($urandom);
                fill_random(rv);
                start_scan(rv, 1'($urandom));
            end
            ticks(80 + $urandom_range(0, 4));
            chk("rand_count", int'(spr_count), exp_total);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
